// File: rtl/eos_sched_mq_pkg.sv
// Shared types and helpers for the egress output scheduler.
package eos_pkg;

  typedef enum logic {S_IDLE = 1'b0, S_OUT = 1'b1} state_e;

  localparam int CQF_Q0    = 0;
  localparam int CQF_Q1    = 1;
  localparam int DEF_LEN_W = 11;
  localparam int DEF_MD_W  = 24;

  // FIFO entry: length in the upper bits, opaque payload in the lower bits
  typedef struct packed {
    logic [DEF_LEN_W-1:0] len;
    logic [DEF_MD_W-1:0]  md;
  } md_ent_t;

  function automatic int qid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eos_sched_mq_md_fifo.sv
// Per-queue metadata FIFO: registered pop data, fall-through head length.
module eos_md_fifo #(
  parameter int LEN_W   = 11,
  parameter int MD_W    = 24,
  parameter int QD_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_i,
  input  logic                    rd_i,
  input  logic [LEN_W+MD_W-1:0]   wdata_i,
  output logic [LEN_W+MD_W-1:0]   rdata_o,
  output logic [LEN_W-1:0]        head_len_o,
  output logic [QD_LOG2:0]        cnt_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int EW    = LEN_W + MD_W;
  localparam int DEPTH = 1 << QD_LOG2;

  logic [EW-1:0]      mem_q [DEPTH];
  logic [QD_LOG2-1:0] wptr_q, rptr_q;
  logic [QD_LOG2:0]   cnt_q;
  logic [EW-1:0]      rdata_q;
  logic               do_wr, do_rd;

  assign full_o     = (cnt_q == (QD_LOG2+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_wr      = wr_i && !full_o;
  assign do_rd      = rd_i && !empty_o;
  assign cnt_o      = cnt_q;
  assign rdata_o    = rdata_q;
  assign head_len_o = mem_q[rptr_q][EW-1:MD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + QD_LOG2'(1);
      if (do_rd) begin
        rptr_q  <= rptr_q + QD_LOG2'(1);
        rdata_q <= mem_q[rptr_q];
      end
      cnt_q <= cnt_q + (QD_LOG2+1)'(do_wr) - (QD_LOG2+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/eos_sched_mq.sv
// Egress scheduler: NUM_Q metadata queues, CQF ping-pong on Q0/Q1,
// token-bucket shaping and strict-priority dequeue under backpressure.
module eos_sched_mq
  import eos_pkg::*;
#(
  parameter int NUM_Q      = 8,
  parameter int MD_W       = 24,
  parameter int LEN_W      = 11,
  parameter int QD_LOG2    = 4,
  parameter int TB_W       = 16,
  parameter int REFILL_CYC = 64,
  parameter int BP_THRESH  = 200
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [MD_W-1:0]                in_md,
  input  logic [qid_w(NUM_Q)-1:0]        in_md_qid,
  input  logic [LEN_W-1:0]               in_md_len,
  input  logic                           in_md_wr,
  input  logic                           in_time_slot_flag,
  input  logic [NUM_Q-1:0]               in_shape_en,
  input  logic [NUM_Q*TB_W-1:0]          in_rate_limit,
  input  logic [TB_W-1:0]                in_depth_limit,
  input  logic [7:0]                     pktout_usedw,
  output logic [MD_W-1:0]                out_md,
  output logic [LEN_W-1:0]               out_md_len,
  output logic [qid_w(NUM_Q)-1:0]        out_md_qid,
  output logic                           out_md_wr,
  output logic [NUM_Q*(QD_LOG2+1)-1:0]   out_q_used_cnt,
  output logic                           out_drop,
  output logic [31:0]                    out_drop_cnt,
  output logic [63:0]                    out_mdin_cnt,
  output logic [63:0]                    out_mdout_cnt
);
  localparam int QW = qid_w(NUM_Q);
  localparam int EW = LEN_W + MD_W;
  localparam int CW = QD_LOG2 + 1;
  localparam int RW = (REFILL_CYC > 1) ? $clog2(REFILL_CYC) : 1;

  state_e                         state_q, state_d;
  logic [QW-1:0]                  sel_q, sel_d, tgt, send;
  logic [NUM_Q-1:0]               wr_en, rd_en, full, empty, elig;
  logic [NUM_Q-1:0][LEN_W-1:0]    head_len;
  logic [NUM_Q-1:0][EW-1:0]       rdata;
  logic [NUM_Q-1:0][CW-1:0]       cnt;
  logic [NUM_Q-1:0][TB_W-1:0]     tok_q, tok_d;
  logic [RW-1:0]                  refill_cnt_q;
  logic                           refill, bp, drop;

  logic [MD_W-1:0]  out_md_q;
  logic [LEN_W-1:0] out_len_q;
  logic [QW-1:0]    out_qid_q;
  logic             out_wr_q, out_drop_q;
  logic [31:0]      drop_cnt_q;
  logic [63:0]      mdin_cnt_q, mdout_cnt_q;

  // Q0/Q1 writes always land in the queue that is not currently sending
  assign send   = in_time_slot_flag ? QW'(CQF_Q1) : QW'(CQF_Q0);
  assign tgt    = (in_md_qid < QW'(2)) ? (in_time_slot_flag ? QW'(CQF_Q0) : QW'(CQF_Q1))
                                       : in_md_qid;
  assign bp     = (pktout_usedw >= 8'(BP_THRESH));
  assign refill = (refill_cnt_q == RW'(REFILL_CYC-1));
  assign drop   = |(wr_en & full);

  for (genvar i = 0; i < NUM_Q; i++) begin : g_q
    assign wr_en[i] = in_md_wr && (tgt == QW'(i));
    assign elig[i]  = !empty[i] && ((i >= 2) || (QW'(i) == send)) &&
                      (!in_shape_en[i] || (tok_q[i] >= TB_W'(head_len[i]))) && !bp;
    eos_md_fifo #(.LEN_W(LEN_W), .MD_W(MD_W), .QD_LOG2(QD_LOG2)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_i       (wr_en[i]),
      .rd_i       (rd_en[i]),
      .wdata_i    ({in_md_len, in_md}),
      .rdata_o    (rdata[i]),
      .head_len_o (head_len[i]),
      .cnt_o      (cnt[i]),
      .full_o     (full[i]),
      .empty_o    (empty[i])
    );
  end

  assign out_q_used_cnt = cnt;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rd_en   = '0;
    case (state_q)
      S_IDLE: if (|elig) begin
        for (int i = NUM_Q-1; i >= 0; i--) if (elig[i]) sel_d = QW'(i);
        rd_en   = elig & (~elig + NUM_Q'(1));
        state_d = S_OUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clamp is computed at TB_W+2 bits so refill overflow and underflow are both visible
  function automatic logic [TB_W-1:0] tok_next(input logic [TB_W-1:0] tok,
      input logic [TB_W-1:0] add, input logic [LEN_W-1:0] sub, input logic [TB_W-1:0] cap);
    logic [TB_W+1:0] s;
    s = {2'b00, tok} + {2'b00, add} - (TB_W+2)'(sub);
    if (s[TB_W+1]) return '0;
    if (s[TB_W:0] > {1'b0, cap}) return cap;
    return s[TB_W-1:0];
  endfunction

  always_comb begin
    tok_d = tok_q;
    for (int i = 0; i < NUM_Q; i++) begin
      if (refill || (state_q == S_OUT && sel_q == QW'(i)))
        tok_d[i] = tok_next(tok_q[i],
                            refill ? in_rate_limit[i*TB_W +: TB_W] : '0,
                            (state_q == S_OUT && sel_q == QW'(i)) ? rdata[sel_q][EW-1:MD_W] : '0,
                            in_depth_limit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      tok_q        <= {NUM_Q{in_depth_limit}};
      refill_cnt_q <= '0;
      out_md_q     <= '0;
      out_len_q    <= '0;
      out_qid_q    <= '0;
      out_wr_q     <= 1'b0;
      out_drop_q   <= 1'b0;
      drop_cnt_q   <= '0;
      mdin_cnt_q   <= '0;
      mdout_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      tok_q        <= tok_d;
      refill_cnt_q <= refill ? '0 : refill_cnt_q + RW'(1);
      out_wr_q     <= (state_q == S_OUT);
      if (state_q == S_OUT) begin
        out_md_q    <= rdata[sel_q][MD_W-1:0];
        out_len_q   <= rdata[sel_q][EW-1:MD_W];
        out_qid_q   <= sel_q;
        mdout_cnt_q <= mdout_cnt_q + 64'd1;
      end
      out_drop_q <= drop;
      if (drop)     drop_cnt_q <= drop_cnt_q + 32'd1;
      if (in_md_wr) mdin_cnt_q <= mdin_cnt_q + 64'd1;
    end
  end

  assign out_md        = out_md_q;
  assign out_md_len    = out_len_q;
  assign out_md_qid    = out_qid_q;
  assign out_md_wr     = out_wr_q;
  assign out_drop      = out_drop_q;
  assign out_drop_cnt  = drop_cnt_q;
  assign out_mdin_cnt  = mdin_cnt_q;
  assign out_mdout_cnt = mdout_cnt_q;

endmodule

// File: tb/tb_eos_sched_mq.sv
// Scoreboard bench for eos_sched_mq: queue-level reference model feeds expected outputs.
module tb_eos_sched_mq;
  localparam int NQ = 8, MDW = 24, LW = 11, TBW = 16, CW = 5;

  logic               clk = 1'b0, rst = 1'b1;
  logic [MDW-1:0]     in_md = '0;
  logic [2:0]         in_md_qid = '0;
  logic [LW-1:0]      in_md_len = '0;
  logic               in_md_wr = 1'b0, in_time_slot_flag = 1'b0;
  logic [NQ-1:0]      in_shape_en = '0;
  logic [NQ*TBW-1:0]  in_rate_limit = '0;
  logic [TBW-1:0]     in_depth_limit = 16'd100;
  logic [7:0]         pktout_usedw = '0;
  logic [MDW-1:0]     out_md;
  logic [LW-1:0]      out_md_len;
  logic [2:0]         out_md_qid;
  logic               out_md_wr, out_drop;
  logic [NQ*CW-1:0]   out_q_used_cnt;
  logic [31:0]        out_drop_cnt;
  logic [63:0]        out_mdin_cnt, out_mdout_cnt;

  eos_sched_mq dut (
    .clk(clk), .rst(rst), .in_md(in_md), .in_md_qid(in_md_qid), .in_md_len(in_md_len),
    .in_md_wr(in_md_wr), .in_time_slot_flag(in_time_slot_flag), .in_shape_en(in_shape_en),
    .in_rate_limit(in_rate_limit), .in_depth_limit(in_depth_limit), .pktout_usedw(pktout_usedw),
    .out_md(out_md), .out_md_len(out_md_len), .out_md_qid(out_md_qid), .out_md_wr(out_md_wr),
    .out_q_used_cnt(out_q_used_cnt), .out_drop(out_drop), .out_drop_cnt(out_drop_cnt),
    .out_mdin_cnt(out_mdin_cnt), .out_mdout_cnt(out_mdout_cnt));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int q; logic [MDW-1:0] md; logic [LW-1:0] len; } ent_t;
  ent_t exp_q[$];
  ent_t mq[NQ][$];
  int   out_stamps[$];
  int   n_cmp = 0, n_bad = 0;
  int   exp_in = 0, exp_out = 0, exp_drop = 0, tot_drop = 0, drop_seen = 0;
  bit   direct = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (out_drop) drop_seen++;
    if (out_md_wr) begin
      out_stamps.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out actual_qid=%0d actual_md=%h required=none", out_md_qid, out_md);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("out_qid", 64'(out_md_qid), 64'(e.q));
        chk("out_md",  64'(out_md),     64'(e.md));
        chk("out_len", 64'(out_md_len), 64'(e.len));
      end
    end
  end

  // Reference enqueue: CQF writes go to the non-sending queue; a full queue drops
  task automatic wr(input int qid, input logic [MDW-1:0] md, input logic [LW-1:0] len);
    ent_t e;
    int   t;
    t = (qid < 2) ? (in_time_slot_flag ? 0 : 1) : qid;
    e.q = t; e.md = md; e.len = len;
    in_md = md; in_md_qid = qid[2:0]; in_md_len = len; in_md_wr = 1'b1;
    @(posedge clk); #1;
    in_md_wr = 1'b0;
    exp_in++;
    if (direct) begin exp_q.push_back(e); exp_out++; end
    else if (mq[t].size() >= 16) begin exp_drop++; tot_drop++; end
    else mq[t].push_back(e);
  endtask

  task automatic drain_one(input int q);
    while (mq[q].size() > 0) begin exp_q.push_back(mq[q].pop_front()); exp_out++; end
  endtask

  // Everything present leaves by strict priority: send queue first, then Q2 upward
  task automatic release_q();
    drain_one(in_time_slot_flag ? 1 : 0);
    for (int q = 2; q < NQ; q++) drain_one(q);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin @(posedge clk); n++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain_timeout actual_left=%0d required=0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic chk_used(input string nm, input int q, input int req);
    chk(nm, 64'(out_q_used_cnt[q*CW +: CW]), 64'(req));
  endtask

  task automatic chk_counters(input string nm);
    chk({nm, "_mdin"},  out_mdin_cnt,  64'(exp_in));
    chk({nm, "_mdout"}, out_mdout_cnt, 64'(exp_out));
    chk({nm, "_dropc"}, 64'(out_drop_cnt), 64'(exp_drop));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_md"},   64'(out_md), 64'd0);
    chk({nm, "_len"},  64'(out_md_len), 64'd0);
    chk({nm, "_qid"},  64'(out_md_qid), 64'd0);
    chk({nm, "_wr"},   64'(out_md_wr), 64'd0);
    chk({nm, "_drop"}, 64'(out_drop), 64'd0);
    chk({nm, "_used"}, 64'(out_q_used_cnt), 64'd0);
    chk_counters(nm);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, s, nw;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // basic FIFO path, latency and throughput
    direct = 1'b1;
    out_stamps.delete();
    wr(4, 24'h000001, 11'd64);
    w0 = cyc;
    wr(4, 24'h000002, 11'd64);
    wr(4, 24'h000003, 11'd64);
    wait_drain("basic");
    if (out_stamps.size() >= 3) begin
      chk("latency", 64'(out_stamps[0] - w0), 64'd2);
      chk("gap1", 64'(out_stamps[1] - out_stamps[0]), 64'd2);
      chk("gap2", 64'(out_stamps[2] - out_stamps[1]), 64'd2);
    end else chk("basic_outs", 64'(out_stamps.size()), 64'd3);
    chk("basic_mdout", out_mdout_cnt, 64'd3);

    // CQF: flag=0 -> qid 0 writes land in Q1 and wait for its slot
    direct = 1'b0;
    in_time_slot_flag = 1'b0;
    wr(0, 24'hC0FFEE, 11'd100);
    wr(0, 24'hC0FFEF, 11'd101);
    repeat (20) @(posedge clk); #1;
    chk_used("cqf_q1_used", 1, 2);
    chk_used("cqf_q0_used", 0, 0);
    chk("cqf_hold_mdout", out_mdout_cnt, 64'(exp_out));
    in_time_slot_flag = 1'b1;
    release_q();
    wait_drain("cqf");

    // strict priority: Q2 ahead of Q5
    pktout_usedw = 8'd250;
    for (int i = 0; i < 4; i++) begin
      wr(5, 24'h500000 + 24'(i), 11'd50 + 11'(i));
      wr(2, 24'h200000 + 24'(i), 11'd20 + 11'(i));
    end
    repeat (5) @(posedge clk); #1;
    release_q();
    pktout_usedw = 8'd0;
    wait_drain("prio");

    // shaping: bucket 100, rate 0, two 64-byte entries -> only one passes until refill
    direct = 1'b1;
    in_shape_en = 8'b0000_1000;
    wr(3, 24'h333001, 11'd64);
    wr(3, 24'h333002, 11'd64);
    repeat (300) @(posedge clk); #1;
    chk("shape_stall_mdout", out_mdout_cnt, 64'(exp_out - 1));
    chk_used("shape_q3_used", 3, 1);
    in_rate_limit[3*TBW +: TBW] = 16'd64;
    wait_drain("shape");
    in_shape_en = '0;
    in_rate_limit = '0;

    // overflow: 17 writes to a stalled queue, last one drops
    direct = 1'b0;
    pktout_usedw = 8'd250;
    for (int i = 0; i < 17; i++) wr(6, 24'h600000 + 24'(i), 11'(i + 1));
    repeat (3) @(posedge clk); #1;
    chk_used("ovf_q6_used", 6, 16);
    chk("ovf_dropcnt", 64'(out_drop_cnt), 64'(exp_drop));
    chk("ovf_drop_pulses", 64'(drop_seen), 64'(tot_drop));
    release_q();
    pktout_usedw = 8'd0;
    wait_drain("ovf");
    chk_counters("ovf");

    // random bursts into stalled queues, then full drain across both CQF slots
    for (int r = 0; r < 3; r++) begin
      pktout_usedw = 8'd250;
      in_time_slot_flag = 1'($urandom_range(0, 1));
      nw = $urandom_range(20, 50);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 7) == 0) in_time_slot_flag = ~in_time_slot_flag;
        wr($urandom_range(0, NQ-1), MDW'($urandom), 11'($urandom_range(1, 2047)));
      end
      release_q();
      pktout_usedw = 8'd0;
      wait_drain("rndA");
      in_time_slot_flag = ~in_time_slot_flag;
      release_q();
      wait_drain("rndA2");
      chk_counters("rndA");
      chk("rndA_used", 64'(out_q_used_cnt), 64'd0);
      chk("rndA_drop_pulses", 64'(drop_seen), 64'(tot_drop));
    end

    // random single-queue traffic with fluctuating backpressure
    direct = 1'b1;
    for (int r = 0; r < 3; r++) begin
      s = $urandom_range(2, NQ-1);
      for (int i = 0; i < 12; i++) begin
        nw = $urandom_range(0, 3);
        for (int k = 0; k < nw; k++) begin
          pktout_usedw = 8'($urandom_range(0, 255));
          @(posedge clk); #1;
        end
        wr(s, MDW'($urandom), 11'($urandom_range(0, 2047)));
      end
      pktout_usedw = 8'd0;
      wait_drain("rndB");
      chk_counters("rndB");
    end

    // reset mid-operation discards queued entries without counting drops
    direct = 1'b0;
    pktout_usedw = 8'd250;
    for (int i = 0; i < 3; i++) wr(2, 24'hEE0000 + 24'(i), 11'd10);
    chk_used("prerst_q2_used", 2, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int q = 0; q < NQ; q++) mq[q].delete();
    exp_in = 0; exp_out = 0; exp_drop = 0;
    chk_zero("midrst");
    rst = 1'b0;
    pktout_usedw = 8'd0;
    repeat (20) @(posedge clk); #1;
    chk("postrst_mdout", out_mdout_cnt, 64'd0);
    chk("postrst_used", 64'(out_q_used_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
